// File: rtl/echo_pkg.sv
// Shared constants and types for the parametrised echo processor.
package echo_pkg;
  localparam int          DW_DEF         = 10;
  localparam int          AW_DEF         = 13;
  localparam logic [9:0]  ADC_OFFSET_DEF = 10'h181;
  localparam logic [9:0]  DAC_OFFSET_DEF = 10'h200;

  localparam logic MODE_FB = 1'b0;
  localparam logic MODE_FF = 1'b1;

  typedef logic signed [DW_DEF-1:0] sample_t;
endpackage

// File: rtl/echo_processor_param_if.sv
// Sample/control bus of the echo processor; slave modport faces the DUT.
interface echo_processor_param_if #(
  parameter int DW = 10,
  parameter int AW = 13
);
  logic          data_valid;
  logic [DW-1:0] data_in;
  logic [AW-1:0] delay;
  logic [2:0]    gain_shift;
  logic          mode;
  logic          bypass;
  logic [DW-1:0] data_out;
  logic          out_valid;

  modport slave (
    input  data_valid, data_in, delay, gain_shift, mode, bypass,
    output data_out, out_valid
  );

  modport master (
    output data_valid, data_in, delay, gain_shift, mode, bypass,
    input  data_out, out_valid
  );
endinterface

// File: rtl/echo_ram.sv
// Simple dual-port 2^AW x DW delay-line RAM with registered read; block-RAM friendly.
module echo_ram #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Write port and registered read port, no reset so the array maps to block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/echo_processor_param.sv
// Programmable-delay echo (feedback or feed-forward) with bypass.
// Define ECHO_SAT_EN to clamp y instead of letting it wrap.
module echo_processor_param
  import echo_pkg::*;
#(
  parameter int          DW         = DW_DEF,
  parameter int          AW         = AW_DEF,
  parameter logic [DW-1:0] ADC_OFFSET = ADC_OFFSET_DEF,
  parameter logic [DW-1:0] DAC_OFFSET = DAC_OFFSET_DEF
) (
  input  logic                   sysclk,
  input  logic                   reset,
  echo_processor_param_if.slave  bus
);
  logic [AW-1:0]        wptr_r;
  logic [AW-1:0]        fill_r;
  logic [AW-1:0]        raddr_s;
  logic                 valid_r;
  logic                 mute_r;
  logic                 mode_r;
  logic [2:0]           shift_r;
  logic signed [DW-1:0] x_s;
  logic signed [DW-1:0] x_r;
  logic [DW-1:0]        rdata_s;
  logic signed [DW-1:0] tap_s;
  logic signed [DW-1:0] echo_s;
  logic signed [DW-1:0] y_s;
  logic [DW-1:0]        wdata_s;
  logic                 we_s;
  logic [DW-1:0]        data_out_r;
  logic                 out_valid_r;

  assign x_s     = bus.data_in - ADC_OFFSET;
  assign raddr_s = wptr_r - bus.delay;
  assign tap_s   = rdata_s;
  assign we_s    = valid_r & ~reset;
  assign wdata_s = (mode_r == MODE_FF) ? x_r : y_s;

  echo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (sysclk),
    .we    (we_s),
    .waddr (wptr_r),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Capture the sample and its controls when the strobe arrives
  always_ff @(posedge sysclk) begin
    if (reset) begin
      valid_r <= 1'b0;
      x_r     <= {DW{1'b0}};
      mute_r  <= 1'b1;
      mode_r  <= MODE_FB;
      shift_r <= 3'd0;
    end else if (bus.data_valid) begin
      valid_r <= 1'b1;
      x_r     <= x_s;
      // fill < delay keeps never-written RAM words out of the echo
      mute_r  <= (bus.gain_shift == 3'd0) || (bus.delay == {AW{1'b0}}) ||
                 bus.bypass || (fill_r < bus.delay);
      mode_r  <= bus.mode;
      shift_r <= bus.gain_shift;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Attenuated tap, forced to zero when the echo is masked
  always_comb begin
    echo_s = {DW{1'b0}};
    if (mute_r) begin
      echo_s = {DW{1'b0}};
    end else begin
      echo_s = tap_s >>> shift_r;
    end
  end

`ifdef ECHO_SAT_EN
  logic signed [DW:0] sum_s;

  function automatic logic signed [DW-1:0] sat_sum(input logic signed [DW:0] v);
    logic signed [DW-1:0] r;
    if (v[DW] != v[DW-1]) begin
      r = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  assign sum_s = {x_r[DW-1], x_r} + {echo_s[DW-1], echo_s};
  assign y_s   = sat_sum(sum_s);
`else
  assign y_s = x_r + echo_s;
`endif

  // Commit y: advance the delay line and present the output for one cycle
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wptr_r      <= {AW{1'b0}};
      fill_r      <= {AW{1'b0}};
      data_out_r  <= DAC_OFFSET;
      out_valid_r <= 1'b0;
    end else if (valid_r) begin
      wptr_r      <= wptr_r + AW'(1);
      fill_r      <= (fill_r == {AW{1'b1}}) ? fill_r : fill_r + AW'(1);
      data_out_r  <= y_s + DAC_OFFSET;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_echo_processor_param.sv
// Table-driven scoreboard bench for echo_processor_param (small AW=3 buffer).
module tb_echo_processor_param;
  import echo_pkg::*;

  localparam int DW = 10;
  localparam int AW = 3;
`ifdef ECHO_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  echo_processor_param_if #(.DW(DW), .AW(AW)) bus ();

  echo_processor_param #(.DW(DW), .AW(AW)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  // pre: 0 = none, 1 = plain reset, 2 = reset while a sample is in flight
  typedef struct {
    int          pre;
    logic [9:0]  din;
    logic [AW-1:0] dly;
    logic [2:0]  shift;
    logic        mode;
    logic        byp;
    logic [9:0]  exp;
    string       tag;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         due_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ncnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int pre, input int din, input int dly,
                              input int sh, input bit m, input bit b,
                              input int e, input string t);
    vec_t v;
    v.pre = pre; v.din = 10'(din); v.dly = AW'(dly); v.shift = 3'(sh);
    v.mode = m; v.byp = b; v.exp = 10'(e); v.tag = t;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v, input bit expect_out);
    @(posedge sysclk); #1;
    bus.data_in    = v.din;
    bus.delay      = v.dly;
    bus.gain_shift = v.shift;
    bus.mode       = v.mode;
    bus.bypass     = v.byp;
    bus.data_valid = 1'b1;
    if (expect_out) begin
      exp_q.push_back(v.exp);
      tag_q.push_back(v.tag);
    end
    @(posedge sysclk); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic plain_reset();
    @(posedge sysclk); #1 reset = 1'b1;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_data_out", int'(bus.data_out), 512);
    @(posedge sysclk); #1 reset = 1'b0;
  endtask

  task automatic mid_reset(input vec_t v);
    drive(v, 1'b0);
    reset = 1'b1;
    @(posedge sysclk);
    repeat (3) begin
      @(negedge sysclk);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_data_out", int'(bus.data_out), 512);
    end
    @(posedge sysclk); #1 reset = 1'b0;
    repeat (3) @(posedge sysclk);
  endtask

  // Scoreboard: strobes schedule a due slot, out_valid pops value and slot
  initial begin
    logic [9:0] e;
    string      t;
    int         d;
    forever begin
      @(negedge sysclk);
      ncnt++;
      if (reset) due_q.delete();
      else if (bus.data_valid) due_q.push_back(ncnt + 2);
      if (bus.out_valid) begin
        if (exp_q.size() == 0 || due_q.size() == 0) begin
          check("spurious_out_valid", int'(bus.out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          d = due_q.pop_front();
          check(t, int'(bus.data_out), int'(e));
          check({t, "_latency"}, ncnt, d);
        end
      end
    end
  end

  initial begin
    int waited;
    bus.data_valid = 1'b0; bus.data_in = 10'd385; bus.delay = AW'(4);
    bus.gain_shift = 3'd1; bus.mode = 1'b0; bus.bypass = 1'b0;

    for (int n = 0; n < 8; n++)
      add((n == 0) ? 1 : 0, 385, 4, 1, 1'b0, 1'b0, 512, $sformatf("silence_n%0d", n));
    for (int n = 0; n < 16; n++)
      add((n == 0) ? 1 : 0, (n == 0) ? 485 : 385, 4, 1, MODE_FB, 1'b0,
          (n == 0) ? 612 : (n == 4) ? 562 : (n == 8) ? 537 : (n == 12) ? 524 : 512,
          $sformatf("fb_imp_n%0d", n));
    for (int n = 0; n < 16; n++)
      add((n == 0) ? 1 : 0, (n == 0) ? 485 : 385, 4, 1, MODE_FF, 1'b0,
          (n == 0) ? 612 : (n == 4) ? 562 : 512, $sformatf("ff_imp_n%0d", n));
    add(1, 885, 1, 1, MODE_FB, 1'b0, 1012, "sat_n0");
    add(0, 885, 1, 1, MODE_FB, 1'b0, SAT ? 1023 : 238, "sat_n1");
    add(0, 385, 1, 1, MODE_FB, 1'b0, SAT ? 767 : 375, "sat_stored_n2");
    add(0, 385, 1, 0, MODE_FB, 1'b0, 512, "gain_shift0_mute");
    for (int n = 0; n < 20; n++)
      add((n == 0) ? 1 : 0, (n == 2) ? 485 : 385, 7, 1, MODE_FB, 1'b0,
          (n == 2) ? 612 : (n == 9) ? 562 : (n == 16) ? 537 : 512,
          $sformatf("wrap_n%0d", n));
    for (int n = 0; n < 8; n++)
      add(0, (n == 0) ? 285 : 485, 4, 1, MODE_FF, 1'b1,
          (n == 0) ? 412 : 612, $sformatf("bypass_n%0d", n));
    for (int n = 0; n < 8; n++)
      add((n == 0) ? 2 : 0, 385, 4, 1, MODE_FB, 1'b0, 512, $sformatf("warmup_n%0d", n));

    repeat (2) @(posedge sysclk);
    foreach (vecs[i]) begin
      if (vecs[i].pre == 1) plain_reset();
      if (vecs[i].pre == 2) mid_reset(vecs[i]);
      drive(vecs[i], 1'b1);
      repeat (3) @(posedge sysclk);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge sysclk);
      waited++;
    end
    check("pending_outputs", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
